adc_frame_pingpong: RTL

Downstream neighbour of the ADC symbol buffer stage in the NB-LDPC PIM read path. Captures PARALLEL soft ADC symbols per cycle into PERIOD-column frames. Double-buffers the frames across two banks, so ADC capture continues while the decoder consumes the previous frame. Each complete frame is handed to the decoder through a valid/ready handshake; overruns are flagged, never silently overwritten.

---
 rtl/adc_pkg.sv | 15 +
 rtl/adc_frame_bank.sv | 31 +++
 rtl/adc_frame_pingpong.sv | 123 ++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared ADC read-path parameters and the soft-symbol column type.
// Used by the symbol buffer stage, the frame ping-pong and the decoder front end.
package adc_pkg;

    localparam int INPUT_BIT   = 3;
    localparam int PARALLEL    = 10;
    localparam int PERIOD      = 32;
    localparam int COUNTER_BIT = 5;

    localparam int COL_W   = PARALLEL * INPUT_BIT;
    localparam int FRAME_W = PERIOD * COL_W;

    typedef logic [PARALLEL-1:0][INPUT_BIT-1:0] column_t;

endpackage

// File: rtl/adc_frame_bank.sv
// One PERIOD-column frame storage bank, written one column at a time.
// Ports: CLK, RST (sync, active-high), we_i/idx_i/col_i write port,
//        frame_o flat frame (column i at bits i*COL_W).
module adc_frame_bank
    import adc_pkg::*;
#(
    parameter int BCOL_W   = COL_W,
    parameter int BPERIOD  = PERIOD,
    parameter int BIDX_W   = COUNTER_BIT
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      we_i,
    input  logic [BIDX_W-1:0]         idx_i,
    input  logic [BCOL_W-1:0]         col_i,
    output logic [BPERIOD*BCOL_W-1:0] frame_o
);

    logic [BPERIOD-1:0][BCOL_W-1:0] mem_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[idx_i] <= col_i;
        end
    end

    assign frame_o = mem_q;

endmodule

// File: rtl/adc_frame_pingpong.sv
// Collects ADC soft-symbol columns into frames, double-buffered over two
// banks, and hands full frames to the decoder over a valid/ready handshake.
// Ports: CLK, RST (sync, active-high), CE write enable, IN_VALID/INPUT column
//        in, FRAME_VALID/FRAME_READY/FRAME_DATA frame out, FRAME_CNT accepted
//        frames, OVERFLOW sticky drop flag, FILL columns in current write bank.
module adc_frame_pingpong
    import adc_pkg::*;
#(
    parameter int P_INPUT_BIT   = INPUT_BIT,
    parameter int P_PARALLEL    = PARALLEL,
    parameter int P_PERIOD      = PERIOD,
    parameter int P_COUNTER_BIT = COUNTER_BIT
) (
    input  logic                                       CLK,
    input  logic                                       RST,
    input  logic                                       CE,
    input  logic                                       IN_VALID,
    input  logic [P_PARALLEL*P_INPUT_BIT-1:0]          INPUT,
    output logic                                       FRAME_VALID,
    input  logic                                       FRAME_READY,
    output logic [P_PERIOD*P_PARALLEL*P_INPUT_BIT-1:0] FRAME_DATA,
    output logic [7:0]                                 FRAME_CNT,
    output logic                                       OVERFLOW,
    output logic [P_COUNTER_BIT-1:0]                   FILL
);

    localparam int CW = P_PARALLEL * P_INPUT_BIT;
    localparam int FW = P_PERIOD * CW;
    localparam logic [P_COUNTER_BIT-1:0] LAST_COL = P_COUNTER_BIT'(P_PERIOD - 1);

    logic [1:0]               full_q, full_d;
    logic                     wsel_q, wsel_d;
    logic                     rsel_q, rsel_d;
    logic [P_COUNTER_BIT-1:0] fill_q, fill_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;

    logic          wr_ok, drop, last, accept;
    logic [FW-1:0] frame0, frame1;

    // Full flags are sampled before the edge, so a bank freed by this
    // edge's acceptance cannot take a column on the same edge.
    assign wr_ok  = CE & IN_VALID & ~full_q[wsel_q];
    assign drop   = CE & IN_VALID &  full_q[wsel_q];
    assign last   = (fill_q == LAST_COL);
    assign accept = full_q[rsel_q] & FRAME_READY;

    always_comb begin
        full_d = full_q;
        wsel_d = wsel_q;
        rsel_d = rsel_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q | drop;
        if (accept) begin
            full_d[rsel_q] = 1'b0;
            rsel_d         = ~rsel_q;
            cnt_d          = cnt_q + 8'd1;
        end
        // Write bank is never full here, so it differs from the read bank
        // being released above.
        if (wr_ok) begin
            if (last) begin
                full_d[wsel_q] = 1'b1;
                wsel_d         = ~wsel_q;
                fill_d         = '0;
            end else begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            full_q <= '0;
            wsel_q <= 1'b0;
            rsel_q <= 1'b0;
            fill_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            wsel_q <= wsel_d;
            rsel_q <= rsel_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    adc_frame_bank #(
        .BCOL_W  (CW),
        .BPERIOD (P_PERIOD),
        .BIDX_W  (P_COUNTER_BIT)
    ) u_bank0 (
        .CLK     (CLK),
        .RST     (RST),
        .we_i    (wr_ok & ~wsel_q),
        .idx_i   (fill_q),
        .col_i   (INPUT),
        .frame_o (frame0)
    );

    adc_frame_bank #(
        .BCOL_W  (CW),
        .BPERIOD (P_PERIOD),
        .BIDX_W  (P_COUNTER_BIT)
    ) u_bank1 (
        .CLK     (CLK),
        .RST     (RST),
        .we_i    (wr_ok & wsel_q),
        .idx_i   (fill_q),
        .col_i   (INPUT),
        .frame_o (frame1)
    );

    assign FRAME_VALID = full_q[rsel_q];
    assign FRAME_DATA  = rsel_q ? frame1 : frame0;
    assign FRAME_CNT   = cnt_q;
    assign OVERFLOW    = ovf_q;
    assign FILL        = fill_q;

endmodule
